// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, redirect flushes,
// data-memory wait handling with timeout, operand forwarding and event counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWEn,
    input  logic             ex_is_load,
    input  logic             ex_PC_Sel,
    input  logic [4:0]       mem_rd,
    input  logic             mem_RegWEn,
    input  logic [4:0]       wb_rd,
    input  logic             wb_RegWEn,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_memwb,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [WCW-1:0]   wait_nxt_s;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_busy_s;
    logic             load_use_s;

    // MEM result outranks WB; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Hazard detection and stall/flush priority (memory wait > redirect > load-use).
    always_comb begin
        mem_busy_s  = dmem_req & ~dmem_ready;
        load_use_s  = ex_is_load & ex_RegWEn & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_memwb = 1'b0;
        if (!rst_n) begin
            stall_pc = 1'b0;
        end else if ((state_q == ERR) || mem_busy_s) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (ex_PC_Sel) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use_s) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end else begin
            stall_pc = 1'b0;
        end
    end

    // Operand forwarding selects, forced to regfile while in reset.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n) begin
            fwd_a = fwd_sel(ex_rs1, mem_rd, mem_RegWEn, wb_rd, wb_RegWEn);
            fwd_b = fwd_sel(ex_rs2, mem_rd, mem_RegWEn, wb_rd, wb_RegWEn);
        end else begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // Memory-wait FSM next state, wait counter, sticky error and event counters.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        wait_nxt_s  = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : (wait_cnt_q + WCW'(1));
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_busy_s) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_nxt_s;
                    // The cycle that brings the count to the limit is the last one tolerated.
                    if (wait_nxt_s == TIMEOUT_V) begin
                        state_d = ERR;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_err_d   = mem_err_q | (state_d == ERR);
        stall_cnt_d = stall_pc   ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;
        flush_cnt_d = flush_ifid ? (flush_cnt_q + CNT_W'(1)) : flush_cnt_q;
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters).
module tb_pipeline_hazard_ctrl;

    logic       clk, rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, ex_RegWEn, ex_is_load, ex_PC_Sel;
    logic       mem_RegWEn, wb_RegWEn, dmem_req, dmem_ready;
    logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic       flush_ifid, flush_idex, flush_memwb, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;
    logic [6:0] ctl;
    logic [3:0] exp_stall, exp_flush;
    int         checks = 0;
    int         errors = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn),
        .ex_is_load(ex_is_load), .ex_PC_Sel(ex_PC_Sel),
        .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_memwb(flush_memwb), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Order: stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_memwb
    assign ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_memwb};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_RegWEn = 1'b0;
        ex_is_load = 1'b0; ex_PC_Sel = 1'b0; mem_rd = 5'd0; mem_RegWEn = 1'b0;
        wb_rd = 5'd0; wb_RegWEn = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    endtask

    // Advance one clock edge, updating the expected counters for the cycle just applied.
    task automatic tick(input logic sp, input logic fi);
        if (sp) exp_stall = exp_stall + 4'd1;
        if (fi) exp_flush = exp_flush + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        set_load_use();
        ex_PC_Sel = 1'b1; dmem_req = 1'b1;
        mem_rd = 5'd7; mem_RegWEn = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
        #2;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL reset_ctl: got %b want 0000000", ctl); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b}); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({stall_cnt, flush_cnt, mem_err} !== 9'd0) begin errors++; $display("FAIL reset_regs: got %h want 0", {stall_cnt, flush_cnt, mem_err}); end
        clear_inputs();
        rst_n = 1'b1;
        exp_stall = 4'd0; exp_flush = 4'd0;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL idle_ctl: got %b want 0000000", ctl); end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_load_use();
        clear_inputs(); set_load_use(); #1;
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL lu_rs1: got %b want 1100010", ctl); end
        tick(1'b1, 1'b0);
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        id_rs1 = 5'd3; id_rs2 = 5'd5; id_rs2_used = 1'b1; #1;
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL lu_rs2: got %b want 1100010", ctl); end
        tick(1'b1, 1'b0);
        id_rs2_used = 1'b0; #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL lu_unused: got %b want 0000000", ctl); end
        tick(1'b0, 1'b0);
        ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL lu_x0: got %b want 0000000", ctl); end
        tick(1'b0, 1'b0);
        set_load_use(); ex_is_load = 1'b0; #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL lu_noload: got %b want 0000000", ctl); end
        tick(1'b0, 1'b0);
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL lu_cnt2: got %0d want %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_redirect();
        clear_inputs(); set_load_use(); ex_PC_Sel = 1'b1; #1;
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL redirect: got %b want 0000110", ctl); end
        tick(1'b0, 1'b1);
        checks++; if ({flush_cnt, stall_cnt} !== {exp_flush, exp_stall}) begin errors++; $display("FAIL redirect_cnt: got %h want %h", {flush_cnt, stall_cnt}, {exp_flush, exp_stall}); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; mem_RegWEn = 1'b1; wb_RegWEn = 1'b1; #1;
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_mem: got %b want 10", fwd_a); end
        mem_RegWEn = 1'b0; #1;
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b want 01", fwd_a); end
        mem_RegWEn = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; #1;
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b want 00", fwd_a); end
        mem_rd = 5'd3; wb_rd = 5'd9; ex_rs1 = 5'd4; ex_rs2 = 5'd9; #1;
        checks++; if ({fwd_a, fwd_b} !== 4'b0001) begin errors++; $display("FAIL fwd_b_wb: got %b want 0001", {fwd_a, fwd_b}); end
        ex_rs2 = 5'd3; #1;
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_b_mem: got %b want 10", fwd_b); end
        tick(1'b0, 1'b0);
    endtask

    // Two back-to-back 3-cycle waits: a stale wait count would trip the timeout.
    task automatic test_mem_wait();
        for (int rep = 0; rep < 2; rep++) begin
            clear_inputs(); dmem_req = 1'b1; ex_PC_Sel = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL wait_ctl rep%0d cyc%0d: got %b want 1111001", rep, c, ctl); end
                tick(1'b1, 1'b0);
            end
            ex_PC_Sel = 1'b0; dmem_ready = 1'b1; #1;
            checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL wait_ready rep%0d: got %b want 0000000", rep, ctl); end
            tick(1'b0, 1'b0);
            dmem_req = 1'b0; dmem_ready = 1'b0;
            tick(1'b0, 1'b0);
            checks++; if ({mem_err, stall_cnt} !== {1'b0, exp_stall}) begin errors++; $display("FAIL wait_done rep%0d: got %h want %h", rep, {mem_err, stall_cnt}, {1'b0, exp_stall}); end
        end
        // Reset in the middle of a wait leaves no residual stall.
        dmem_req = 1'b1; tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        rst_n = 1'b0; clear_inputs(); #2; rst_n = 1'b1;
        exp_stall = 4'd0; exp_flush = 4'd0;
        tick(1'b0, 1'b0);
        checks++; if ({ctl, mem_err, stall_cnt} !== 12'd0) begin errors++; $display("FAIL wait_reset: got %h want 0", {ctl, mem_err, stall_cnt}); end
    endtask

    task automatic test_timeout();
        clear_inputs(); dmem_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick(1'b1, 1'b0);
            if (c >= 3) begin
                checks++;
                if (mem_err !== (c == 5)) begin errors++; $display("FAIL timeout_err edge%0d: got %b want %b", c, mem_err, (c == 5)); end
            end
        end
        dmem_req = 1'b0; ex_PC_Sel = 1'b1; set_load_use(); #1;
        checks++; if ({ctl, mem_err} !== 8'b11110011) begin errors++; $display("FAIL err_ctl: got %b want 11110011", {ctl, mem_err}); end
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        checks++; if ({mem_err, stall_cnt} !== {1'b1, exp_stall}) begin errors++; $display("FAIL err_sticky: got %h want %h", {mem_err, stall_cnt}, {1'b1, exp_stall}); end
        rst_n = 1'b0; dmem_req = 1'b1; #2;
        checks++; if ({ctl, mem_err, stall_cnt, flush_cnt} !== 16'd0) begin errors++; $display("FAIL err_in_reset: got %h want 0", {ctl, mem_err, stall_cnt, flush_cnt}); end
        clear_inputs(); rst_n = 1'b1; exp_stall = 4'd0; exp_flush = 4'd0; #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL err_exit: got %b want 0000000", ctl); end
        tick(1'b0, 1'b0);
        checks++; if ({mem_err, stall_cnt} !== 5'd0) begin errors++; $display("FAIL err_cleared: got %h want 0", {mem_err, stall_cnt}); end
    endtask

    task automatic test_back_to_back();
        clear_inputs(); set_load_use();
        for (int c = 0; c < 17; c++) tick(1'b1, 1'b0);
        checks++; if (stall_cnt !== 4'd1 || exp_stall !== 4'd1) begin errors++; $display("FAIL stall_wrap: got %0d want 1", stall_cnt); end
        ex_PC_Sel = 1'b1;
        for (int c = 0; c < 3; c++) tick(1'b0, 1'b1);
        checks++; if ({flush_cnt, stall_cnt} !== {exp_flush, exp_stall}) begin errors++; $display("FAIL flush_run: got %h want %h", {flush_cnt, stall_cnt}, {exp_flush, exp_stall}); end
    endtask

    initial begin
        rst_n = 1'b0;
        exp_stall = 4'd0; exp_flush = 4'd0;
        test_reset();
        test_load_use();
        test_redirect();
        test_forwarding();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
